// File: rtl/pe_conv_mac_buffer_split.sv
// Slice serializer: takes one full-width channel word and emits it as
// NUM_SLICES consecutive pOUTPUT_PARALLEL-wide slices, least-significant first.
module pe_conv_mac_buffer_split #(
  parameter  int pDATA_WIDTH      = 8,
  parameter  int pOUT_CHANNEL     = 32,
  parameter  int pOUTPUT_PARALLEL = 32,
  localparam int NUM_SLICES       = pOUT_CHANNEL / pOUTPUT_PARALLEL,
  localparam int IDX_W            = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [pDATA_WIDTH*pOUT_CHANNEL-1:0]     data_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [pDATA_WIDTH*pOUTPUT_PARALLEL-1:0] data_out,
  output logic [IDX_W-1:0]                      out_idx,
  output logic                                  out_last,
  output logic                                  busy
);

  localparam int SLICE_W = pDATA_WIDTH * pOUTPUT_PARALLEL;

  generate
    if ((pOUT_CHANNEL % pOUTPUT_PARALLEL) != 0 || NUM_SLICES < 1) begin : g_bad_cfg
      $error("pOUT_CHANNEL must be a positive integer multiple of pOUTPUT_PARALLEL");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                             state, state_next;
  logic [NUM_SLICES-1:0][SLICE_W-1:0] word_r;
  logic [IDX_W-1:0]                   idx_r, idx_next;
  logic                               at_last, in_fire, out_fire;

  assign at_last  = (idx_r == IDX_W'(NUM_SLICES - 1));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx_r <= '0;
    end else begin
      state <= state_next;
      idx_r <= idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
    end else if (in_fire) begin
      word_r <= data_in;
    end
  end

  // A new word loading on the final slice's handshake keeps SEND with no bubble.
  always_comb begin
    state_next = state;
    idx_next   = idx_r;
    if (clear) begin
      state_next = IDLE;
      idx_next   = '0;
    end else if (in_fire) begin
      state_next = SEND;
      idx_next   = '0;
    end else if (out_fire) begin
      if (at_last) begin
        state_next = IDLE;
        idx_next   = '0;
      end else begin
        idx_next = idx_r + IDX_W'(1);
      end
    end
  end

  always_comb begin
    out_valid = (state == SEND);
    busy      = (state == SEND);
    out_last  = (state == SEND) && at_last;
    out_idx   = idx_r;
    in_ready  = !clear && ((state == IDLE) || (out_ready && at_last));
  end

  generate
    if (NUM_SLICES == 1) begin : g_single
      assign data_out = word_r;
    end else begin : g_multi
      assign data_out = word_r[idx_r];
    end
  endgenerate

endmodule

// File: doc/pe_conv_mac_buffer_split.md
Name: pe_conv_mac_buffer_split

Overview:
Output-side slice serializer for the conv MAC path, the counterpart of the slice-gather buffer that assembles a full pOUT_CHANNEL-wide word from pOUTPUT_PARALLEL-wide slices.
- Accepts one full-width channel word over a valid/ready handshake.
- Emits it as NUM_SLICES = pOUT_CHANNEL/pOUTPUT_PARALLEL consecutive slices, each tagged with its slice index and a last flag.
- Sits between a full-width producer (bias/requant stage or line buffer) and any pOUTPUT_PARALLEL-wide consumer, or the gather buffer's wr_en/buffer_idx/data_in.

Parameters:
- pDATA_WIDTH, 8: bits per channel element.
- pOUT_CHANNEL, 32: channels in the full input word.
- pOUTPUT_PARALLEL, 32: channels per emitted slice. pOUT_CHANNEL must be an integer multiple of it; elaboration fails otherwise.
- Derived: NUM_SLICES = pOUT_CHANNEL/pOUTPUT_PARALLEL.
- Derived: IDX_W = max(1, $clog2(NUM_SLICES)).

Ports:
- clk, input, 1: clock. All logic is on posedge.
- rst_n, input, 1: asynchronous active-low reset. It is already decided that reset is asynchronous and active-low, and this port is named rst_n.
- clear, input, 1: synchronous abort. Drops any word in flight.
- in_valid, input, 1: producer has a full word.
- in_ready, output, 1: block can take a full word this cycle.
- data_in, input, pDATA_WIDTH*pOUT_CHANNEL: full channel word. Channel c occupies bits [c*pDATA_WIDTH +: pDATA_WIDTH].
- out_valid, output, 1: slice on data_out is valid.
- out_ready, input, 1: consumer accepts the slice.
- data_out, output, pDATA_WIDTH*pOUTPUT_PARALLEL: current slice.
- out_idx, output, IDX_W: index of the current slice, 0..NUM_SLICES-1.
- out_last, output, 1: high when out_idx == NUM_SLICES-1 and out_valid is high.
- busy, output, 1: a word is held (state SEND).

Behaviour:
- Storage:
  - One word register word_r.
  - Slice counter idx_r.
  - State: IDLE (no word held) or SEND (word held).
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and idx_r to 0.
  - word_r is cleared to 0.
  - Outputs: out_valid=0, in_ready=1 (as soon as reset deasserts), busy=0, out_idx=0, out_last=0, data_out=0.
  - Reset asserted mid-word discards that word. No partial slices are emitted after reset.
- Slice selection: data_out = word_r[idx_r*pDATA_WIDTH*pOUTPUT_PARALLEL +: pDATA_WIDTH*pOUTPUT_PARALLEL]. Slice 0 is the least-significant slice and is emitted first.
- Output signals: out_valid = (state==SEND). out_idx = idx_r. All outputs are driven straight from registers/mux, with no combinational path from out_ready or in_valid to out_valid/data_out.
- Input accept: in_ready = (state==IDLE) || (state==SEND && out_ready && idx_r==NUM_SLICES-1). The only input-to-output path is out_ready to in_ready, which allows back-to-back words with zero bubble.
- Input handshake fire: in_valid && in_ready. On fire, word_r <= data_in, idx_r <= 0, state <= SEND.
- Output handshake fire: out_valid && out_ready.
  - If idx_r < NUM_SLICES-1: idx_r <= idx_r+1.
  - If idx_r == NUM_SLICES-1 and no input fire in the same cycle: state <= IDLE and idx_r <= 0.
  - If idx_r == NUM_SLICES-1 and an input fire occurs in the same cycle: the new word loads and state stays SEND.
- Backpressure: while out_valid=1 and out_ready=0, data_out, out_idx and out_last hold stable. out_valid never deasserts without a handshake, except on clear or reset.
- Timing:
  - Latency from input fire to first out_valid is 1 cycle.
  - With out_ready held high, NUM_SLICES slices come out on consecutive cycles.
  - Sustained throughput is 1 word per NUM_SLICES cycles.
- NUM_SLICES == 1: the block degenerates to a 1-entry pipeline register. out_idx is always 0, out_last = out_valid, and in_ready = !busy || out_ready.
- clear:
  - Takes priority over both handshakes in the same cycle.
  - Next state is IDLE and idx_r is 0. word_r is unchanged; it is don't-care.
  - in_ready is forced to 0 during the clear cycle, so no word is accepted that cycle.
- data_in is sampled only on input fire. Changes while in_ready=0 have no effect.

Test Plan:
Configuration for scenarios 1-5: pDATA_WIDTH=8, pOUT_CHANNEL=8, pOUTPUT_PARALLEL=2, giving NUM_SLICES=4.

1. Basic split, out_ready=1: one input fire with data_in=64'h0807060504030201.
   -> Next 4 cycles data_out = 16'h0201, 0403, 0605, 0807.
   -> out_idx = 0, 1, 2, 3; out_last only on idx 3.
   -> in_ready=0 during idx 0-2, then 1 at idx 3; state returns to IDLE.
2. Back-to-back words: in_valid held high with words A=64'h1111_2222_3333_4444 and B=64'hAAAA_BBBB_CCCC_DDDD.
   -> 8 consecutive valid cycles with no gap.
   -> B is accepted in the cycle where A's idx 3 fires.
   -> Emission order is 4444, 3333, 2222, 1111, DDDD, CCCC, BBBB, AAAA.
3. Backpressure: out_ready=0 for 3 cycles while at idx 1.
   -> data_out holds 16'h0403, out_idx holds 1, out_valid stays 1.
   -> Resumes at idx 2 when out_ready rises. No slice is lost or duplicated.
4. Abort: clear asserted while at idx 2 with in_valid=1 the same cycle.
   -> Next cycle out_valid=0, busy=0.
   -> The word offered during the clear cycle is not accepted.
   -> A new word offered afterwards starts at idx 0.
5. Async reset: rst_n pulled low mid-cycle at idx 1.
   -> out_valid drops immediately without waiting for a clock edge; in_ready=1 after release.
   -> The next word emits from idx 0.
6. Degenerate configuration (defaults 32/32, NUM_SLICES=1): 5 words streamed with random out_ready.
   -> Each word appears exactly once, unchanged, with out_last=1 and out_idx=0.
   -> Throughput is 1 word/cycle when out_ready=1.
